// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: single-port AXI4 memory slave, INCR bursts only.
// Independent write (AW/W/B) and read (AR/R) FSMs share one word array.
// Optional macro AXI4_MEM_SLAVE_ADDR_CHECK_EN: out-of-range word indices
// give SLVERR (no write, read data 0) instead of wrapping modulo DEPTH.
module axi4_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] w_idx;
    logic [7:0]        w_len, w_cnt;
    logic              w_err, w_end, w_beat_err, w_oob, aw_fire, w_fire;

    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_idx, r_fetch_idx;
    logic [7:0]        r_len, r_cnt;
    logic              r_end, r_oob, ar_fire, r_fire, r_adv;

    // Indices are kept untruncated so the range check sees the real word index.
    assign w_end       = (w_cnt == w_len);
    assign w_beat_err  = (wlast != w_end);
    assign r_end       = (r_cnt == r_len);
    assign r_fetch_idx = (r_state == R_IDLE) ? (araddr >> OFF) : (r_idx + ADDR_W'(1));

`ifdef AXI4_MEM_SLAVE_ADDR_CHECK_EN
    assign w_oob = (w_idx >= ADDR_W'(DEPTH));
    assign r_oob = (r_fetch_idx >= ADDR_W'(DEPTH));
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;
    assign r_adv   = r_fire && !r_end;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state and handshake outputs; all outputs low during reset.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !reset;
                if (awvalid && !reset) w_next = W_DATA;
            end
            W_DATA: begin
                wready = !reset;
                if (wvalid && w_end) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = !reset;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst bookkeeping; burst length from awlen alone, wlast only flags errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_err <= 1'b0;
            bresp <= OKAY;
        end else begin
            if (aw_fire) begin
                w_idx <= awaddr >> OFF;
                w_len <= awlen;
                w_cnt <= '0;
                w_err <= 1'b0;
            end
            if (w_fire) begin
                if (w_end) begin
                    bresp <= (w_err || w_beat_err || w_oob) ? SLVERR : OKAY;
                end else begin
                    w_idx <= w_idx + ADDR_W'(1);
                    w_cnt <= w_cnt + 8'd1;
                    w_err <= w_err || w_beat_err || w_oob;
                end
            end
        end
    end

    // Byte-enabled memory write; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_fire && !w_oob) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[w_idx[AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !reset;
                if (arvalid && !reset) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = !reset;
                rlast  = !reset && r_end;
                if (rready && r_end) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read data register: loaded on AR or on a non-last beat, held on stall.
    // Same-edge read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_len <= '0;
            r_cnt <= '0;
            rdata <= '0;
            rresp <= OKAY;
        end else if (ar_fire || r_adv) begin
            r_idx <= r_fetch_idx;
            r_cnt <= ar_fire ? 8'd0 : r_cnt + 8'd1;
            if (ar_fire) r_len <= arlen;
            rdata <= r_oob ? '0 : mem[r_fetch_idx[AW-1:0]];
            rresp <= r_oob ? SLVERR : OKAY;
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: a table of single-beat write/read
// vectors plus hand sequences for bursts, stalls, wlast errors and reset.
module tb_axi4_mem_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi4_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    logic [31:0] wbuf   [16];
    logic [31:0] rbuf   [16];
    logic [1:0]  rrespb [16];
    logic        rlastb [16];
    int          nbeat;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input int last_at,
                            input logic [3:0] strb, input int hold, output logic [1:0] resp);
        int t;
        @(negedge clk);
        awaddr = addr; awlen = len; awvalid = 1'b1; t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1; t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        resp = bresp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bvalid_hold", 64'(bvalid), 64'd1);
            chk("bresp_hold", 64'(bresp), 64'(resp));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_drop", 64'(bvalid), 64'd0);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
        int t;
        bit stalled;
        logic [31:0] pd;
        logic [1:0]  pr;
        logic        pl;
        @(negedge clk);
        araddr = addr; arlen = len; arvalid = 1'b1; t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        nbeat = 0; stalled = 1'b0; t = 0;
        pd = '0; pr = '0; pl = 1'b0;
        while (nbeat <= int'(len) && t < 100) begin
            if (stalled) begin
                chk("rdata_stall", 64'(rdata), 64'(pd));
                chk("rresp_stall", 64'(rresp), 64'(pr));
                chk("rlast_stall", 64'(rlast), 64'(pl));
            end
            rready = toggle ? t[0] : 1'b1;
            pd = rdata; pr = rresp; pl = rlast;
            if (rready && rvalid) begin
                rbuf[nbeat] = rdata; rrespb[nbeat] = rresp; rlastb[nbeat] = rlast;
                nbeat++;
            end
            stalled = !rready;
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        if (nbeat <= int'(len)) chk("read_timeout", 64'(nbeat), 64'(len) + 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp;

        tv[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        tv[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        tv[2]  = '{1'b1, 32'h20,  32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        tv[3]  = '{1'b1, 32'h20,  32'h00000000, 4'h5, 2'b00, 32'h0};
        tv[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 2'b00, 32'hFF00FF00};
        tv[5]  = '{1'b1, 32'h24,  32'h11223344, 4'hF, 2'b00, 32'h0};
        tv[6]  = '{1'b1, 32'h24,  32'hA5A5A5A5, 4'h8, 2'b00, 32'h0};
        tv[7]  = '{1'b0, 32'h24,  32'h0,        4'h0, 2'b00, 32'hA5223344};
        tv[8]  = '{1'b1, 32'h0,   32'h12345678, 4'hF, 2'b00, 32'h0};
`ifdef AXI4_MEM_SLAVE_ADDR_CHECK_EN
        tv[9]  = '{1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0};
        tv[10] = '{1'b0, 32'h0,   32'h0,        4'h0, 2'b00, 32'h12345678};
        tv[11] = '{1'b0, 32'h400, 32'h0,        4'h0, 2'b10, 32'h0};
`else
        tv[9]  = '{1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
        tv[10] = '{1'b0, 32'h0,   32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
        tv[11] = '{1'b0, 32'h400, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
`endif

        reset = 1'b1;
        awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        chk("rst_bresp",   64'(bresp),   64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_awready", 64'(awready), 64'd1);
        chk("post_rst_arready", 64'(arready), 64'd1);

        // Table of single-beat accesses.
        for (int v = 0; v < 12; v++) begin
            if (tv[v].wr) begin
                wbuf[0] = tv[v].data;
                wr_burst(tv[v].addr, 8'd0, 0, tv[v].strb, 0, resp);
                chk($sformatf("vec%0d_bresp", v), 64'(resp), 64'(tv[v].resp));
            end else begin
                rd_burst(tv[v].addr, 8'd0, 1'b0);
                chk($sformatf("vec%0d_rdata", v), 64'(rbuf[0]), 64'(tv[v].exp));
                chk($sformatf("vec%0d_rresp", v), 64'(rrespb[0]), 64'(tv[v].resp));
                chk($sformatf("vec%0d_rlast", v), 64'(rlastb[0]), 64'd1);
            end
        end

        // 4-beat write then 4-beat read with rready toggling.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wr_burst(32'h40, 8'd3, 3, 4'hF, 0, resp);
        chk("burst_bresp", 64'(resp), 64'd0);
        rd_burst(32'h40, 8'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_rdata%0d", i), 64'(rbuf[i]), 64'(i + 1));
            chk($sformatf("burst_rlast%0d", i), 64'(rlastb[i]), 64'(i == 3));
        end

        // Early wlast: SLVERR, burst still two beats, bvalid held with bready low.
        wbuf[0] = 32'h0BAD0001; wbuf[1] = 32'h0BAD0002;
        wr_burst(32'h60, 8'd1, 0, 4'hF, 3, resp);
        chk("wlast_err_bresp", 64'(resp), 64'd2);
        rd_burst(32'h64, 8'd0, 1'b0);
        chk("wlast_err_beat2", 64'(rbuf[0]), 64'h0BAD0002);
        wbuf[0] = 32'h77;
        wr_burst(32'h68, 8'd0, 0, 4'hF, 0, resp);
        chk("err_cleared_bresp", 64'(resp), 64'd0);

        // Reset during beat 2 of a 4-beat read.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h80 + 32'(i);
        wr_burst(32'h80, 8'd3, 3, 4'hF, 0, resp);
        @(negedge clk);
        chk("mid_rst_arready", 64'(arready), 64'd1);
        araddr = 32'h80; arlen = 8'd3; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("mid_rst_beat1", 64'(rdata), 64'h80);
        @(negedge clk);
        chk("mid_rst_beat2", 64'(rdata), 64'h81);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_rdata",  64'(rdata),  64'd0);
        chk("mid_rst_rlast",  64'(rlast),  64'd0);
        chk("mid_rst_arready_low", 64'(arready), 64'd0);
        reset = 1'b0; rready = 1'b0;
        #1;
        chk("after_rst_arready", 64'(arready), 64'd1);
        chk("after_rst_awready", 64'(awready), 64'd1);
        rd_burst(32'h8C, 8'd0, 1'b0);
        chk("mem_retained", 64'(rbuf[0]), 64'h83);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
